// File: rtl/spi_globals_pkg.sv
// spi_globals_pkg: shared state type and default sizing for the SPI slave transfer controller
package spi_globals_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
  localparam int DEF_DATA_WIDTH = 8;
  // Wide enough that truncating to any practical word width still yields all-ones
  localparam logic [63:0] DEF_FILL_WORD = '1;
endpackage

// File: rtl/spi_slave_xfer_ctrl_if.sv
// spi_slave_xfer_ctrl_if: tx word handshake and rx word strobe between the SPI slave and its user
interface spi_slave_xfer_ctrl_if import spi_globals_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic tx_valid;
  logic tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic rx_valid;
  logic [DATA_WIDTH-1:0] rx_data;
  modport slave (input tx_valid, tx_data, output tx_ready, rx_valid, rx_data);
  modport master (output tx_valid, tx_data, input tx_ready, rx_valid, rx_data);
endinterface

// File: rtl/spi_slave_sync_edge.sv
// spi_slave_sync_edge: multi-flop synchronizer with one-cycle rise/fall strobes on the synced level
module spi_slave_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic pclk,
  input  logic areset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  // Reset to low so a pin already low at release never looks like a falling edge
  always_ff @(posedge pclk) begin
    if (!areset) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= STAGES'({sync, din});
      prev <= sync[STAGES-1];
    end
  end
  assign level = sync[STAGES-1];
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/spi_slave_xfer_ctrl.sv
// spi_slave_xfer_ctrl: SPI slave word engine with tx holding register, rx word strobe and status flags
module spi_slave_xfer_ctrl import spi_globals_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] FILL_WORD = DATA_WIDTH'(DEF_FILL_WORD)
) (
  input  logic pclk,
  input  logic areset,
  input  logic cfg_cpol,
  input  logic cfg_cpha,
  input  logic cfg_msb_first,
  input  logic sclk,
  input  logic cs,
  input  logic mosi0,
  output logic miso0,
  spi_slave_xfer_ctrl_if.slave bus,
  output logic busy,
  output logic underrun,
  output logic abort
);
  localparam int CW = $clog2(DATA_WIDTH);
  state_t state, nxt;
  logic sclk_s, sclk_r, sclk_f, cs_s, cs_r, cs_f, mosi_s, mosi_r, mosi_f, unused_pins;
  logic cpol, cpha, msb, done, hold_full, rdy_en;
  logic in_sh, lead, trail, smp, shf, load_pt, emit, msb_e, last, hs, src_bit;
  logic [CW-1:0] cnt;
  logic [DATA_WIDTH-1:0] hold, tx_sh, rx_sh, word, src, src_sh, rx_nxt;

  spi_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk (
    .pclk(pclk), .areset(areset), .din(sclk), .level(sclk_s), .rise(sclk_r), .fall(sclk_f));
  spi_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_cs (
    .pclk(pclk), .areset(areset), .din(cs), .level(cs_s), .rise(cs_r), .fall(cs_f));
  spi_slave_sync_edge #(.STAGES(SYNC_STAGES)) u_mosi (
    .pclk(pclk), .areset(areset), .din(mosi0), .level(mosi_s), .rise(mosi_r), .fall(mosi_f));
  assign unused_pins = ^{sclk_s, cs_s, mosi_r, mosi_f};

  always_ff @(posedge pclk) begin
    if (!areset) state <= ST_IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    if (state == ST_IDLE && cs_f) nxt = ST_LOAD;
    if (state == ST_LOAD) nxt = ST_SHIFT;
    if (state == ST_SHIFT && cs_r) nxt = ST_IDLE;
  end

  // LOAD works from the live cfg pins because the captured copies only settle at its end
  always_comb begin
    in_sh = state == ST_SHIFT && !cs_r;
    lead = cpol ? sclk_f : sclk_r;
    trail = cpol ? sclk_r : sclk_f;
    smp = in_sh && (cpha ? trail : lead);
    shf = in_sh && (cpha ? lead : trail);
    load_pt = state == ST_LOAD || (shf && done);
    emit = shf || (state == ST_LOAD && !cfg_cpha);
    msb_e = state == ST_LOAD ? cfg_msb_first : msb;
    hs = bus.tx_valid && bus.tx_ready;
    word = hold_full ? hold : bus.tx_valid ? bus.tx_data : FILL_WORD;
    src = load_pt ? word : tx_sh;
    src_bit = msb_e ? src[DATA_WIDTH-1] : src[0];
    src_sh = msb_e ? src << 1 : src >> 1;
    rx_nxt = msb ? {rx_sh[DATA_WIDTH-2:0], mosi_s} : {mosi_s, rx_sh[DATA_WIDTH-1:1]};
    last = cnt == CW'(DATA_WIDTH - 1);
  end

  always_ff @(posedge pclk) begin
    if (!areset) begin
      {miso0, underrun, abort, hold_full, rdy_en, done, cpol, cpha, msb} <= '0;
      bus.rx_valid <= 1'b0;
      bus.rx_data <= '0;
      cnt <= '0;
      hold <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
    end else begin
      rdy_en <= 1'b1;
      bus.rx_valid <= 1'b0;
      abort <= 1'b0;
      if (hs && !load_pt) begin
        hold <= bus.tx_data;
        hold_full <= 1'b1;
      end
      if (load_pt) hold_full <= 1'b0;
      if (state == ST_LOAD) begin
        cpol <= cfg_cpol;
        cpha <= cfg_cpha;
        msb <= cfg_msb_first;
        underrun <= 1'b0;
        cnt <= '0;
        done <= 1'b0;
      end
      if (load_pt && !hold_full && !bus.tx_valid) underrun <= 1'b1;
      if (emit) begin
        miso0 <= src_bit;
        tx_sh <= src_sh;
      end else if (load_pt) tx_sh <= src;
      if (shf) done <= 1'b0;
      if (smp) begin
        rx_sh <= rx_nxt;
        cnt <= last ? '0 : cnt + 1'b1;
        if (last) begin
          bus.rx_data <= rx_nxt;
          bus.rx_valid <= 1'b1;
          done <= 1'b1;
        end
      end
      // A partial word at deselect is dropped and flagged
      if (state == ST_SHIFT && cs_r) begin
        miso0 <= 1'b0;
        abort <= cnt != '0;
        cnt <= '0;
        done <= 1'b0;
      end
    end
  end

  assign bus.tx_ready = rdy_en && !hold_full;
  assign busy = state != ST_IDLE;
endmodule

// File: tb/tb_spi_slave_xfer_ctrl.sv
// tb_spi_slave_xfer_ctrl: directed SPI master transfers against hand-computed expectations
module tb_spi_slave_xfer_ctrl;
  localparam int HALF = 8;
  logic pclk = 1'b0, areset = 1'b0, cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_msb_first = 1'b1;
  logic sclk = 1'b0, cs = 1'b1, mosi0 = 1'b0;
  logic miso0, busy, underrun, abort;
  int n_chk = 0, n_err = 0, rx_cnt = 0, ab_cnt = 0, r0, a0, q0;
  logic [7:0] rx_q[$];
  logic [7:0] mi, mi2;

  spi_slave_xfer_ctrl_if #(.DATA_WIDTH(8)) bus();

  spi_slave_xfer_ctrl #(.DATA_WIDTH(8), .SYNC_STAGES(2), .FILL_WORD(8'hFF)) dut (
    .pclk(pclk), .areset(areset), .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha),
    .cfg_msb_first(cfg_msb_first), .sclk(sclk), .cs(cs), .mosi0(mosi0), .miso0(miso0),
    .bus(bus), .busy(busy), .underrun(underrun), .abort(abort));

  always #5 pclk = ~pclk;

  always @(negedge pclk) begin
    if (bus.rx_valid) begin
      rx_cnt++;
      rx_q.push_back(bus.rx_data);
    end
    if (abort) ab_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  task automatic set_mode(input logic pol, input logic pha, input logic msbf);
    cfg_cpol = pol;
    cfg_cpha = pha;
    cfg_msb_first = msbf;
    sclk = pol;
    cyc(4);
  endtask

  task automatic push(input logic [7:0] d);
    int k = 0;
    while (!bus.tx_ready && k < 50) begin
      cyc(1);
      k++;
    end
    chk("push_ready", bus.tx_ready, 1);
    bus.tx_valid = 1'b1;
    bus.tx_data = d;
    cyc(1);
    bus.tx_valid = 1'b0;
  endtask

  task automatic cs_low();
    cs = 1'b0;
    cyc(HALF);
  endtask

  task automatic cs_high();
    cyc(HALF);
    cs = 1'b1;
    cyc(HALF);
  endtask

  task automatic xword(input logic [7:0] mo, input int nbits, output logic [7:0] mi_o);
    mi_o = '0;
    for (int i = 0; i < nbits; i++) begin
      int idx = cfg_msb_first ? 7 - i : i;
      if (!cfg_cpha) begin
        mosi0 = mo[idx];
        cyc(HALF);
        mi_o[idx] = miso0;
        sclk = ~cfg_cpol;
        cyc(HALF);
        sclk = cfg_cpol;
      end else begin
        sclk = ~cfg_cpol;
        mosi0 = mo[idx];
        cyc(HALF);
        mi_o[idx] = miso0;
        sclk = cfg_cpol;
        cyc(HALF);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.tx_valid = 1'b0;
    bus.tx_data = '0;
    cyc(4);
    chk("rst_tx_ready", bus.tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_miso", miso0, 0);
    chk("rst_rx_valid", bus.rx_valid, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_abort", abort, 0);
    areset = 1'b1;
    cyc(1);
    chk("rel_tx_ready", bus.tx_ready, 1);

    set_mode(1'b0, 1'b0, 1'b1);
    push(8'hA5);
    chk("m0_hold_full", bus.tx_ready, 0);
    r0 = rx_cnt;
    a0 = ab_cnt;
    cs_low();
    chk("m0_busy", busy, 1);
    chk("m0_hold_drained", bus.tx_ready, 1);
    xword(8'h3C, 8, mi);
    cs_high();
    chk("m0_miso", mi, 8'hA5);
    chk("m0_rx_cnt", rx_cnt - r0, 1);
    chk("m0_rx_data", bus.rx_data, 8'h3C);
    chk("m0_abort", ab_cnt - a0, 0);
    chk("m0_idle", busy, 0);
    chk("m0_miso_idle", miso0, 0);

    set_mode(1'b1, 1'b1, 1'b0);
    push(8'h01);
    r0 = rx_cnt;
    q0 = rx_q.size();
    cs_low();
    push(8'h80);
    xword(8'hF0, 8, mi);
    xword(8'h0F, 8, mi2);
    cs_high();
    chk("m3_miso_w0", mi, 8'h01);
    chk("m3_miso_w1", mi2, 8'h80);
    chk("m3_rx_cnt", rx_cnt - r0, 2);
    chk("m3_rx_w0", rx_q[q0], 8'hF0);
    chk("m3_rx_w1", rx_q[q0+1], 8'h0F);
    chk("m3_underrun", underrun, 0);

    set_mode(1'b0, 1'b1, 1'b1);
    cs_low();
    xword(8'h5A, 8, mi);
    cs_high();
    chk("m1_fill", mi, 8'hFF);
    chk("m1_underrun", underrun, 1);
    chk("m1_rx_data", bus.rx_data, 8'h5A);

    set_mode(1'b0, 1'b0, 1'b1);
    push(8'h3C);
    r0 = rx_cnt;
    a0 = ab_cnt;
    cs_low();
    chk("ab_underrun_clr", underrun, 0);
    xword(8'h00, 5, mi);
    cs_high();
    chk("ab_pulse", ab_cnt - a0, 1);
    chk("ab_no_rx", rx_cnt - r0, 0);
    chk("ab_idle", busy, 0);
    push(8'h96);
    cs_low();
    xword(8'h69, 8, mi);
    cs_high();
    chk("ab_next_miso", mi, 8'h96);
    chk("ab_next_rx_cnt", rx_cnt - r0, 1);
    chk("ab_next_rx_data", bus.rx_data, 8'h69);

    set_mode(1'b0, 1'b1, 1'b1);
    cs = 1'b0;
    cyc(3);
    chk("byp_in_load", busy, 1);
    bus.tx_valid = 1'b1;
    bus.tx_data = 8'hC3;
    chk("byp_ready_hs", bus.tx_ready, 1);
    cyc(1);
    bus.tx_valid = 1'b0;
    chk("byp_ready_after", bus.tx_ready, 1);
    chk("byp_underrun", underrun, 0);
    cyc(HALF - 4);
    xword(8'h11, 8, mi);
    cs_high();
    chk("byp_miso", mi, 8'hC3);
    chk("byp_underrun_end", underrun, 0);

    set_mode(1'b0, 1'b0, 1'b1);
    push(8'hE7);
    cs_low();
    xword(8'hFF, 3, mi);
    areset = 1'b0;
    cyc(1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_miso", miso0, 0);
    chk("mid_rst_rx_valid", bus.rx_valid, 0);
    chk("mid_rst_rx_data", bus.rx_data, 0);
    chk("mid_rst_underrun", underrun, 0);
    chk("mid_rst_abort", abort, 0);
    chk("mid_rst_tx_ready", bus.tx_ready, 0);
    cyc(2);
    areset = 1'b1;
    cyc(1);
    chk("mid_rel_tx_ready", bus.tx_ready, 1);
    cyc(12);
    chk("mid_cs_low_no_start", busy, 0);
    cs = 1'b1;
    cyc(HALF);
    push(8'h5A);
    r0 = rx_cnt;
    cs_low();
    xword(8'hC3, 8, mi);
    cs_high();
    chk("mid_after_miso", mi, 8'h5A);
    chk("mid_after_rx_cnt", rx_cnt - r0, 1);
    chk("mid_after_rx_data", bus.rx_data, 8'hC3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
